// File: rtl/rally_judge.sv
// rtl/rally_judge.sv - rally referee: serve, touch counting, point award and game scoring
module rally_judge #(
  parameter int WIN_SCORE       = 15,
  parameter int WIN_MARGIN      = 2,
  parameter int MAX_TOUCHES     = 3,
  parameter int NET_LEFT        = 500,
  parameter int NET_RIGHT       = 523,
  parameter int SCORE_W         = 5,
  parameter int WAIT_CYCLES     = 255,
  parameter int WHISTLE_CYCLES  = 50,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gnd_col,
  input  logic               col_p1,
  input  logic               col_p2,
  input  logic [11:0]        xposball,
  input  logic               restart,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               serve_side,
  output logic               point_winner,
  output logic               winner,
  output logic               point_pulse,
  output logic               fault,
  output logic               whistle,
  output logic               endgame
);

  localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int WHIS_W = ($clog2(WHISTLE_CYCLES + 1) > 0) ? $clog2(WHISTLE_CYCLES + 1) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TCH_W  = $clog2(MAX_TOUCHES + 2);

  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
  localparam logic [SCORE_W:0]   WIN_S       = (SCORE_W+1)'(WIN_SCORE);
  localparam logic [SCORE_W:0]   WIN_M       = (SCORE_W+1)'(WIN_MARGIN);
  localparam logic [TCH_W-1:0]   TOUCH_LIMIT = TCH_W'(MAX_TOUCHES);
  localparam logic [11:0]        NET_L       = 12'(NET_LEFT);
  localparam logic [11:0]        NET_R       = 12'(NET_RIGHT);
  localparam logic [WAIT_W-1:0]  WAIT_LAST   = WAIT_W'(WAIT_CYCLES - 1);
  localparam logic [WHIS_W-1:0]  WHIS_LIM    = WHIS_W'(WHISTLE_CYCLES);
  localparam logic [DEB_W-1:0]   DEB_LOAD    = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_PLAY  = 3'd1,
    S_POINT = 3'd2,
    S_WAIT  = 3'd3,
    S_END   = 3'd4
  } state_t;

  state_t             state, next_state;
  logic [TCH_W-1:0]   cnt_p1, cnt_p2;
  logic               last_toucher;
  logic [DEB_W-1:0]   deb_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [WHIS_W-1:0]  whis_cnt, whis_next;

  logic               fault_cond, gnd_side, game_over;
  logic               serve_hit, touch_en, award, award_side, fault_set;
  logic               to_start, clear_game, to_end;
  logic [SCORE_W:0]   s1_w, s2_w, lead, top;

  assign fault_cond = (cnt_p1 > TOUCH_LIMIT) || (cnt_p2 > TOUCH_LIMIT);
  // Inside the net zone the ball is blamed on whoever touched it last.
  assign gnd_side   = (xposball < NET_L) ? 1'b1 :
                      (xposball > NET_R) ? 1'b0 : ~last_toucher;

  assign s1_w = {1'b0, score_p1};
  assign s2_w = {1'b0, score_p2};
  assign top  = (s1_w >= s2_w) ? s1_w : s2_w;
  assign lead = (s1_w >= s2_w) ? (s1_w - s2_w) : (s2_w - s1_w);
  assign game_over = ((top >= WIN_S) && (lead >= WIN_M)) ||
                     (score_p1 == SCORE_MAX) || (score_p2 == SCORE_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_START;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_START: if (serve_side ? col_p2 : col_p1) next_state = S_PLAY;
      S_PLAY:  if (gnd_col || fault_cond)        next_state = S_POINT;
      S_POINT: next_state = game_over ? S_END : S_WAIT;
      S_WAIT:  if (wait_cnt == WAIT_LAST)         next_state = S_START;
      S_END:   if (restart)                       next_state = S_START;
      default: next_state = S_START;
    endcase
  end

  always_comb begin
    serve_hit  = (state == S_START) && (next_state == S_PLAY);
    touch_en   = (state == S_PLAY) && (deb_cnt == '0) && (col_p1 || col_p2);
    award      = (state == S_PLAY) && (next_state == S_POINT);
    award_side = gnd_col ? gnd_side : (cnt_p1 > TOUCH_LIMIT);
    fault_set  = award && !gnd_col;
    to_start   = (next_state == S_START) && (state != S_START);
    to_end     = (state == S_POINT) && (next_state == S_END);
    clear_game = (state == S_END) && restart;
    whis_next  = '0;
    if (state == S_START)
      whis_next = (whis_cnt < WHIS_LIM) ? whis_cnt + WHIS_W'(1) : whis_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_p1     <= '0;
      score_p2     <= '0;
      serve_side   <= 1'b0;
      point_winner <= 1'b0;
      winner       <= 1'b0;
      point_pulse  <= 1'b0;
      fault        <= 1'b0;
      whistle      <= 1'b0;
      endgame      <= 1'b0;
      cnt_p1       <= '0;
      cnt_p2       <= '0;
      last_toucher <= 1'b0;
      deb_cnt      <= '0;
      wait_cnt     <= '0;
      whis_cnt     <= '0;
    end else begin
      point_pulse <= award;
      whis_cnt    <= whis_next;
      whistle     <= (next_state == S_START) && (whis_next < WHIS_LIM);
      wait_cnt    <= (state == S_WAIT) ? wait_cnt + WAIT_W'(1) : '0;

      if (to_start) begin
        cnt_p1  <= '0;
        cnt_p2  <= '0;
        deb_cnt <= '0;
      end else if (serve_hit) begin
        cnt_p1       <= serve_side ? '0 : TCH_W'(1);
        cnt_p2       <= serve_side ? TCH_W'(1) : '0;
        last_toucher <= serve_side;
        deb_cnt      <= DEB_LOAD;
      end else if (touch_en) begin
        deb_cnt <= DEB_LOAD;
        // Simultaneous touches count for both sides and clear neither.
        if (col_p1 && col_p2) begin
          if (cnt_p1 <= TOUCH_LIMIT) cnt_p1 <= cnt_p1 + TCH_W'(1);
          if (cnt_p2 <= TOUCH_LIMIT) cnt_p2 <= cnt_p2 + TCH_W'(1);
        end else if (col_p1) begin
          if (cnt_p1 <= TOUCH_LIMIT) cnt_p1 <= cnt_p1 + TCH_W'(1);
          cnt_p2       <= '0;
          last_toucher <= 1'b0;
        end else begin
          if (cnt_p2 <= TOUCH_LIMIT) cnt_p2 <= cnt_p2 + TCH_W'(1);
          cnt_p1       <= '0;
          last_toucher <= 1'b1;
        end
      end else if (deb_cnt != '0) begin
        deb_cnt <= deb_cnt - DEB_W'(1);
      end

      if (award) begin
        if (award_side) begin
          if (score_p2 != SCORE_MAX) score_p2 <= score_p2 + SCORE_W'(1);
        end else begin
          if (score_p1 != SCORE_MAX) score_p1 <= score_p1 + SCORE_W'(1);
        end
        point_winner <= award_side;
        serve_side   <= award_side;
        fault        <= fault_set;
      end

      if (to_end) begin
        endgame <= 1'b1;
        winner  <= point_winner;
      end

      if ((state == S_WAIT) && (next_state == S_START)) fault <= 1'b0;

      if (clear_game) begin
        score_p1   <= '0;
        score_p2   <= '0;
        serve_side <= 1'b0;
        endgame    <= 1'b0;
        fault      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rally_judge.sv
// tb/tb_rally_judge.sv - directed self-checking bench for rally_judge
module tb_rally_judge;

  localparam logic [2:0] ST_START = 3'd0;
  localparam logic [2:0] ST_PLAY  = 3'd1;
  localparam logic [2:0] ST_POINT = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_END   = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        gnd_col, col_p1, col_p2, restart;
  logic [11:0] xposball;
  logic [4:0]  score_p1, score_p2;
  logic        serve_side, point_winner, winner, point_pulse, fault, whistle, endgame;

  int n_cmp = 0;
  int n_bad = 0;

  rally_judge dut (
    .clk(clk), .rst(rst), .gnd_col(gnd_col), .col_p1(col_p1), .col_p2(col_p2),
    .xposball(xposball), .restart(restart), .score_p1(score_p1), .score_p2(score_p2),
    .serve_side(serve_side), .point_winner(point_winner), .winner(winner),
    .point_pulse(point_pulse), .fault(fault), .whistle(whistle), .endgame(endgame)
  );

  initial forever #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic col(input logic a, input logic b);
    col_p1 = a; col_p2 = b;
    tick(1);
    col_p1 = 1'b0; col_p2 = 1'b0;
  endtask

  task automatic wait_start();
    int k;
    k = 0;
    while (dut.state !== ST_START && k < 1000) begin tick(1); k++; end
    n_cmp++;
    if (dut.state !== ST_START) begin n_bad++; $display("FAIL wait_start: state %0d expected %0d", dut.state, ST_START); end
  endtask

  task automatic play_point(input logic side);
    wait_start();
    col(~serve_side, serve_side);
    tick(2);
    xposball = side ? 12'd100 : 12'd900;
    gnd_col = 1'b1; tick(1); gnd_col = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b0; gnd_col = 0; col_p1 = 0; col_p2 = 0; restart = 0; xposball = 12'd0;
    tick(2);
    n_cmp++; if (dut.state !== ST_START) begin n_bad++; $display("FAIL reset_state: got %0d expected %0d", dut.state, ST_START); end
    n_cmp++; if (score_p1 !== 5'd0 || score_p2 !== 5'd0) begin n_bad++; $display("FAIL reset_scores: got %0d:%0d expected 0:0", score_p1, score_p2); end
    n_cmp++; if ({serve_side, point_winner, winner, point_pulse, fault, whistle, endgame} !== 7'd0) begin n_bad++;
      $display("FAIL reset_flags: got %b expected 0000000", {serve_side, point_winner, winner, point_pulse, fault, whistle, endgame}); end
    rst = 1'b1;
    tick(1);
    n_cmp++; if (whistle !== 1'b1) begin n_bad++; $display("FAIL whistle_on: got %b expected 1", whistle); end
    tick(60);
    n_cmp++; if (whistle !== 1'b0) begin n_bad++; $display("FAIL whistle_off: got %b expected 0", whistle); end
  endtask

  task automatic test_serve();
    col(1'b0, 1'b1);
    tick(2);
    n_cmp++; if (dut.state !== ST_START) begin n_bad++; $display("FAIL wrong_server: state %0d expected %0d", dut.state, ST_START); end
    col(1'b1, 1'b0);
    n_cmp++; if (dut.state !== ST_PLAY) begin n_bad++; $display("FAIL serve_play: state %0d expected %0d", dut.state, ST_PLAY); end
    n_cmp++; if (dut.cnt_p1 !== 3'd1) begin n_bad++; $display("FAIL serve_count: got %0d expected 1", dut.cnt_p1); end
  endtask

  task automatic test_fault();
    for (int i = 0; i < 3; i++) begin tick(16); col(1'b1, 1'b0); end
    n_cmp++; if (dut.cnt_p1 !== 3'd4 || fault !== 1'b0) begin n_bad++; $display("FAIL fourth_touch: cnt %0d fault %b expected 4 0", dut.cnt_p1, fault); end
    tick(1);
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL fault_set: got %b expected 1", fault); end
    n_cmp++; if (score_p2 !== 5'd1 || score_p1 !== 5'd0) begin n_bad++; $display("FAIL fault_score: got %0d:%0d expected 0:1", score_p1, score_p2); end
    n_cmp++; if (serve_side !== 1'b1 || point_pulse !== 1'b1) begin n_bad++; $display("FAIL fault_serve: serve %b pulse %b expected 1 1", serve_side, point_pulse); end
    tick(1);
    n_cmp++; if (point_pulse !== 1'b0 || dut.state !== ST_WAIT) begin n_bad++; $display("FAIL pulse_width: pulse %b state %0d expected 0 %0d", point_pulse, dut.state, ST_WAIT); end
    wait_start();
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL fault_clear: got %b expected 0", fault); end
  endtask

  task automatic test_held_and_net();
    col(1'b0, 1'b1);
    tick(16);
    col_p1 = 1'b1; tick(10); col_p1 = 1'b0;
    n_cmp++; if (dut.cnt_p1 !== 3'd1 || dut.cnt_p2 !== 3'd0) begin n_bad++; $display("FAIL held_touch: cnt %0d/%0d expected 1/0", dut.cnt_p1, dut.cnt_p2); end
    tick(16);
    col(1'b0, 1'b1);
    xposball = 12'd510; gnd_col = 1'b1; tick(1); gnd_col = 1'b0;
    n_cmp++; if (score_p1 !== 5'd1 || score_p2 !== 5'd1 || point_winner !== 1'b0) begin n_bad++;
      $display("FAIL net_zone: got %0d:%0d pw %b expected 1:1 pw 0", score_p1, score_p2, point_winner); end
    wait_start();
    col(1'b1, 1'b0);
    tick(2);
    xposball = 12'd499; gnd_col = 1'b1; tick(1); gnd_col = 1'b0;
    n_cmp++; if (score_p2 !== 5'd2 || point_winner !== 1'b1 || serve_side !== 1'b1) begin n_bad++;
      $display("FAIL left_side: got p2 %0d pw %b ss %b expected 2 1 1", score_p2, point_winner, serve_side); end
  endtask

  task automatic test_endgame();
    for (int i = 0; i < 13; i++) play_point(1'b0);
    for (int i = 0; i < 12; i++) play_point(1'b1);
    n_cmp++; if (score_p1 !== 5'd14 || score_p2 !== 5'd14 || endgame !== 1'b0) begin n_bad++;
      $display("FAIL deuce: got %0d:%0d end %b expected 14:14 0", score_p1, score_p2, endgame); end
    play_point(1'b0);
    n_cmp++; if (score_p1 !== 5'd15 || endgame !== 1'b0 || dut.state !== ST_WAIT) begin n_bad++;
      $display("FAIL lead_one: got %0d end %b state %0d expected 15 0 %0d", score_p1, endgame, dut.state, ST_WAIT); end
    play_point(1'b0);
    n_cmp++; if (score_p1 !== 5'd16 || endgame !== 1'b1 || winner !== 1'b0 || dut.state !== ST_END) begin n_bad++;
      $display("FAIL game_won: got %0d end %b win %b state %0d expected 16 1 0 %0d", score_p1, endgame, winner, dut.state, ST_END); end
    col(1'b1, 1'b1);
    tick(2);
    n_cmp++; if (dut.state !== ST_END || score_p1 !== 5'd16) begin n_bad++; $display("FAIL end_ignore: state %0d score %0d expected %0d 16", dut.state, score_p1, ST_END); end
    restart = 1'b1; tick(1); restart = 1'b0;
    n_cmp++; if (score_p1 !== 5'd0 || score_p2 !== 5'd0 || endgame !== 1'b0 || serve_side !== 1'b0 || dut.state !== ST_START) begin n_bad++;
      $display("FAIL restart: got %0d:%0d end %b ss %b state %0d expected 0:0 0 0 %0d", score_p1, score_p2, endgame, serve_side, dut.state, ST_START); end
  endtask

  task automatic test_reset_wait();
    play_point(1'b1);
    n_cmp++; if (dut.state !== ST_WAIT || score_p2 !== 5'd1) begin n_bad++; $display("FAIL pre_reset: state %0d p2 %0d expected %0d 1", dut.state, score_p2, ST_WAIT); end
    tick(99);
    rst = 1'b0;
    #1;
    n_cmp++; if (dut.state !== ST_START || score_p2 !== 5'd0 || serve_side !== 1'b0 || point_winner !== 1'b0) begin n_bad++;
      $display("FAIL async_reset: state %0d p2 %0d ss %b pw %b expected %0d 0 0 0", dut.state, score_p2, serve_side, point_winner, ST_START); end
    tick(2);
    rst = 1'b1;
    tick(1);
    n_cmp++; if (dut.state !== ST_START || whistle !== 1'b1 || score_p1 !== 5'd0 || score_p2 !== 5'd0) begin n_bad++;
      $display("FAIL post_reset: state %0d whistle %b score %0d:%0d expected %0d 1 0:0", dut.state, whistle, score_p1, score_p2, ST_START); end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_fault();
    test_held_and_net();
    test_endgame();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
